// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op/state encodings and operand helpers for the HI/LO unit
package mult_div_unit_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;
  function automatic logic is_md_op(input md_op_t op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_div_op(input md_op_t op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_signed_op(input md_op_t op);
    return op == MD_MULT || op == MD_DIV;
  endfunction
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
    return (s && v[DATA_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage request, abort, stall and HI/LO bundle
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;
  logic              ex_valid;
  md_op_t            ex_op;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic              abort;
  logic              mult_div_run;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  modport master(
    output ex_valid, ex_op, ex_rs_val, ex_rt_val, abort,
    input  mult_div_run, hi, lo
  );
  modport slave(
    input  ex_valid, ex_op, ex_rs_val, ex_rt_val, abort,
    output mult_div_run, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_div_iter.sv
// mult_div_unit_div_iter: unsigned restoring divider, one quotient bit per step
module mult_div_unit_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  logic [W-1:0] dvs;
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         ge;
  assign shifted = {remainder, quotient[W-1]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[W-1:0] - dvs;
  // quotient reg doubles as the dividend shifter; a divisor of 0 yields all-ones and the dividend as remainder
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
    end else if (step) begin
      remainder <= ge ? diff : shifted[W-1:0];
      quotient  <= {quotient[W-2:0], ge};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MUL/DIV engine owning the architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_BITS   = DATA_W
) (
  input logic            clk,
  input logic            resetn,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2((DIV_BITS > MUL_CYCLES ? DIV_BITS : MUL_CYCLES) + 1);
  md_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_a, op_b, quo, rem, div_hi, div_lo, res_hi, res_lo, hi_d, lo_d;
  logic [63:0]       ext_a, ext_b, prod, mul_res;
  logic              sgn, op_div, start, cnt_last, mt_ok, hi_we, lo_we;
  assign start    = bus.ex_valid && is_md_op(bus.ex_op) && !bus.abort && state == ST_IDLE;
  assign mt_ok    = bus.ex_valid && !bus.abort && state == ST_IDLE;
  assign cnt_last = cnt == CNT_W'(state == ST_MUL ? MUL_CYCLES - 1 : DIV_BITS - 1);
  assign ext_a    = {{32{sgn & op_a[31]}}, op_a};
  assign ext_b    = {{32{sgn & op_b[31]}}, op_b};
  assign prod     = ext_a * ext_b;
  assign div_lo   = op_b == '0 ? '1 : (sgn && (op_a[31] ^ op_b[31])) ? -quo : quo;
  assign div_hi   = op_b == '0 ? op_a : (sgn && op_a[31]) ? -rem : rem;
  assign res_hi   = op_div ? div_hi : mul_res[63:32];
  assign res_lo   = op_div ? div_lo : mul_res[31:0];
  mult_div_unit_div_iter #(.W(DIV_BITS)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (start && is_div_op(bus.ex_op)),
    .step     (state == ST_DIV),
    .dividend (mag(bus.ex_rs_val, is_signed_op(bus.ex_op))),
    .divisor  (mag(bus.ex_rt_val, is_signed_op(bus.ex_op))),
    .quotient (quo),
    .remainder(rem)
  );
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end
  // next state, stall request and HI/LO write selection; DONE never accepts a new start
  always_comb begin
    state_nxt = state == ST_IDLE ? (start ? (is_div_op(bus.ex_op) ? ST_DIV : ST_MUL) : ST_IDLE)
              : (state == ST_DONE || bus.abort) ? ST_IDLE
              : cnt_last ? ST_DONE : state;
    bus.mult_div_run = start || state == ST_MUL || state == ST_DIV;
    hi_we = state == ST_DONE ? !bus.abort : mt_ok && bus.ex_op == MD_MTHI;
    lo_we = state == ST_DONE ? !bus.abort : mt_ok && bus.ex_op == MD_MTLO;
    hi_d  = state == ST_DONE ? res_hi : bus.ex_rs_val;
    lo_d  = state == ST_DONE ? res_lo : bus.ex_rs_val;
  end
  // operand capture, iteration counter and product register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a    <= '0;
      op_b    <= '0;
      sgn     <= 1'b0;
      op_div  <= 1'b0;
      cnt     <= '0;
      mul_res <= '0;
    end else begin
      if (start) begin
        op_a   <= bus.ex_rs_val;
        op_b   <= bus.ex_rt_val;
        sgn    <= is_signed_op(bus.ex_op);
        op_div <= is_div_op(bus.ex_op);
      end
      cnt <= (state == ST_MUL || state == ST_DIV) ? cnt + CNT_W'(1) : '0;
      if (state == ST_MUL) mul_res <= prod;
    end
  end
  // architectural HI/LO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      if (hi_we) bus.hi <= hi_d;
      if (lo_we) bus.lo <= lo_d;
    end
  end
endmodule
